// File: rtl/puf_pkg.sv
// Shared types and helpers for the delay-race PUF initiator: FSM state encoding,
// default widths and the challenge rotation used between races.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT,
        CAPTURE,
        RECOVER,
        DONE
    } race_state_t;

    localparam int PUF_CHAL_W     = 32;
    localparam int PUF_RESP_W     = 8;
    localparam int PUF_CHAL_MAX_W = 64;
    localparam int PUF_IDX_W      = 6;

    // Rotate the low 'width' bits of base left by 'amount' (modulo width); upper bits return 0.
    function automatic logic [PUF_CHAL_MAX_W-1:0] rotl_chal(
        input logic [PUF_CHAL_MAX_W-1:0] base,
        input int unsigned               amount,
        input int unsigned               width = PUF_CHAL_W
    );
        logic [PUF_CHAL_MAX_W-1:0] rot;
        int unsigned               pos;
        rot = '0;
        for (int unsigned i = 0; i < PUF_CHAL_MAX_W; i++) begin
            if (i < width) begin
                pos = (i + amount) % width;
                rot[pos[PUF_IDX_W-1:0]] = base[i[PUF_IDX_W-1:0]];
            end
        end
        return rot;
    endfunction

endpackage

// File: rtl/race_launcher_sync_2ff.sv
// Single-bit two-flop synchronizer for arbiter signals arriving asynchronously to clk.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/race_launcher.sv
// Delay-race initiator: applies rotated challenges, launches races, collects one bit per race.
// Define RACE_LAUNCHER_MAJORITY_EN to race each bit three times and keep the majority value.
module race_launcher
    import puf_pkg::*;
#(
    parameter int CHAL_W      = PUF_CHAL_W,
    parameter int RESP_W      = PUF_RESP_W,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    output logic              busy,
    output logic [CHAL_W-1:0] chal_out,
    output logic              launch,
    output logic              arb_reset,
    input  logic              arb_done,
    input  logic              arb_out,
    output logic              resp_valid,
    output logic [RESP_W-1:0] resp,
    output logic              timeout_err
);

    localparam int BIT_W  = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYC - 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST   = WCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(RESP_W - 1);

    race_state_t       state, state_next;
    logic [CHAL_W-1:0] base_chal;
    logic [BIT_W-1:0]  bit_idx;
    logic [SCNT_W-1:0] settle_cnt;
    logic [WCNT_W-1:0] wait_cnt;
    logic [RESP_W-1:0] resp_acc, resp_acc_next;
    logic              done_s, out_s;
    logic              settle_done, wait_expired, last_race;

    sync_2ff u_sync_done (.clk(clk), .reset(reset), .d(arb_done), .q(done_s));
    sync_2ff u_sync_out  (.clk(clk), .reset(reset), .d(arb_out),  .q(out_s));

    assign settle_done  = (settle_cnt == SETTLE_LAST);
    assign wait_expired = (wait_cnt == WAIT_LAST);

`ifdef RACE_LAUNCHER_MAJORITY_EN
    logic [1:0] race_cnt;
    logic [1:0] vote_cnt;

    assign last_race = (race_cnt == 2'd2);

    // The vote lands in the accumulator on the last RECOVER cycle of the third race.
    always_comb begin
        resp_acc_next = resp_acc;
        if (state == RECOVER && last_race)
            resp_acc_next[bit_idx] = (vote_cnt >= 2'd2);
    end
`else
    assign last_race = 1'b1;

    always_comb begin
        resp_acc_next = resp_acc;
    end
`endif

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        arb_reset  = 1'b1;
        busy       = 1'b1;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = LOAD;
            end
            LOAD: begin
                if (settle_done) state_next = FIRE;
            end
            FIRE: begin
                launch     = 1'b1;
                arb_reset  = 1'b0;
                state_next = WAIT;
            end
            WAIT: begin
                launch    = 1'b1;
                arb_reset = 1'b0;
                if (done_s)            state_next = CAPTURE;
                else if (wait_expired) state_next = RECOVER;
            end
            CAPTURE: begin
                launch     = 1'b1;
                arb_reset  = 1'b0;
                state_next = RECOVER;
            end
            RECOVER: begin
                if (settle_done)
                    state_next = (last_race && bit_idx == BIT_LAST) ? DONE : LOAD;
            end
            DONE: begin
                busy       = 1'b0;
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            base_chal   <= '0;
            chal_out    <= '0;
            bit_idx     <= '0;
            settle_cnt  <= '0;
            wait_cnt    <= '0;
            resp_acc    <= '0;
            resp        <= '0;
            timeout_err <= 1'b0;
`ifdef RACE_LAUNCHER_MAJORITY_EN
            race_cnt    <= '0;
            vote_cnt    <= '0;
`endif
        end else begin
            state      <= state_next;
            settle_cnt <= ((state == LOAD || state == RECOVER) && !settle_done)
                          ? settle_cnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_chal   <= challenge;
                        chal_out    <= challenge;
                        bit_idx     <= '0;
                        resp_acc    <= '0;
                        timeout_err <= 1'b0;
`ifdef RACE_LAUNCHER_MAJORITY_EN
                        race_cnt    <= '0;
                        vote_cnt    <= '0;
`endif
                    end
                end
                FIRE: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A late done still wins over a coincident timeout.
                    if (!done_s && wait_expired) begin
                        timeout_err <= 1'b1;
`ifndef RACE_LAUNCHER_MAJORITY_EN
                        resp_acc[bit_idx] <= 1'b0;
`endif
                    end
                end
                CAPTURE: begin
`ifdef RACE_LAUNCHER_MAJORITY_EN
                    vote_cnt <= vote_cnt + {1'b0, out_s};
`else
                    resp_acc[bit_idx] <= out_s;
`endif
                end
                RECOVER: begin
                    if (settle_done) begin
                        resp_acc <= resp_acc_next;
`ifdef RACE_LAUNCHER_MAJORITY_EN
                        if (!last_race) begin
                            race_cnt <= race_cnt + 1'b1;
                        end else begin
                            race_cnt <= '0;
                            vote_cnt <= '0;
                        end
`endif
                        if (last_race) begin
                            if (bit_idx == BIT_LAST) begin
                                resp <= resp_acc_next;
                            end else begin
                                bit_idx  <= bit_idx + 1'b1;
                                chal_out <= CHAL_W'(rotl_chal(PUF_CHAL_MAX_W'(base_chal),
                                                              32'(bit_idx) + 32'd1, CHAL_W));
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_race_launcher.sv
// Scoreboard bench for race_launcher: directed requests against a behavioural arbiter model.
module tb_race_launcher;

    localparam int CHAL_W      = 32;
    localparam int RESP_W      = 4;
    localparam int SETTLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 16;
`ifdef RACE_LAUNCHER_MAJORITY_EN
    localparam int NR        = 3;
    localparam int EXP_VALID = 1;
`else
    localparam int NR        = 1;
    localparam int EXP_VALID = 5;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [CHAL_W-1:0] challenge = '0;
    logic              busy, launch, arb_reset, resp_valid, timeout_err;
    logic [CHAL_W-1:0] chal_out;
    logic [RESP_W-1:0] resp;
    logic              arb_done = 1'b0;
    logic              arb_out = 1'b0;

    int n_cmp = 0, n_fail = 0;
    int valid_cnt = 0, launch_cnt = 0, race_base = 0;
    int inv_err = 0, stab_err = 0;
    logic [15:0] pat_out = '0, pat_nodone = '0;
    logic [4:0]  sb_q[$];
    logic [31:0] chal_q[$];

    race_launcher #(
        .CHAL_W(CHAL_W), .RESP_W(RESP_W), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .challenge(challenge), .busy(busy),
        .chal_out(chal_out), .launch(launch), .arb_reset(arb_reset), .arb_done(arb_done),
        .arb_out(arb_out), .resp_valid(resp_valid), .resp(resp), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Arbiter model: done five cycles into a race unless suppressed, winner from pat_out.
    initial begin
        int lcnt;
        int idx;
        lcnt = 0;
        idx  = 0;
        forever begin
            @(negedge clk);
            if (arb_reset !== 1'b0) begin
                arb_done = 1'b0;
                arb_out  = 1'b0;
                lcnt     = 0;
            end else if (launch === 1'b1) begin
                if (lcnt == 0) begin
                    idx = launch_cnt - race_base;
                    launch_cnt++;
                    arb_out = pat_out[idx[3:0]];
                end
                lcnt++;
                if (lcnt >= 5 && !pat_nodone[idx[3:0]]) arb_done = 1'b1;
            end
        end
    end

    // Monitor: challenge per race, stability while launched, and response scoreboard.
    initial begin
        logic        lp;
        logic [31:0] held;
        logic [31:0] exp_c;
        logic [4:0]  e;
        lp   = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (launch === 1'b0 && arb_reset !== 1'b1) inv_err++;
            if (launch === 1'b1 && !lp) begin
                if (chal_q.size() == 0) begin
                    fail_event("unexpected_race");
                end else begin
                    exp_c = chal_q.pop_front();
                    check("chal_out", chal_out, exp_c);
                end
                held = chal_out;
            end else if (launch === 1'b1 && chal_out !== held) begin
                stab_err++;
            end
            lp = (launch === 1'b1);
            if (resp_valid === 1'b1) begin
                valid_cnt++;
                if (sb_q.size() == 0) begin
                    fail_event("unexpected_resp_valid");
                end else begin
                    e = sb_q.pop_front();
                    check("resp", 32'(resp), 32'(e[3:0]));
                    check("timeout_err_at_valid", 32'(timeout_err), 32'(e[4]));
                    check("busy_at_valid", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic push_chals(input logic [31:0] c);
        logic [31:0] rc;
        rc = c;
        for (int b = 0; b < RESP_W; b++) begin
            for (int r = 0; r < NR; r++) chal_q.push_back(rc);
            rc = {rc[30:0], rc[31]};
        end
    endtask

    task automatic pulse_start(input logic [31:0] c);
        @(negedge clk);
        start     = 1'b1;
        challenge = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int target);
        for (int i = 0; i < 3000 && valid_cnt < target; i++) @(negedge clk);
        if (valid_cnt < target) fail_event("resp_valid_wait_expired");
    endtask

    task automatic run_req(input logic [31:0] c, input logic [15:0] outs, input logic [15:0] nodone,
                           input logic [3:0] exp_resp, input logic exp_to);
        int target;
        pat_out    = outs;
        pat_nodone = nodone;
        race_base  = launch_cnt;
        sb_q.push_back({exp_to, exp_resp});
        push_chals(c);
        target = valid_cnt + 1;
        pulse_start(c);
        check("busy_after_start", 32'(busy), 32'd1);
        check("timeout_cleared_on_start", 32'(timeout_err), 32'd0);
        wait_valid(target);
    endtask

    initial begin
        int vbefore;
        int target;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_launch", 32'(launch), 32'd0);
        check("rst_arb_reset", 32'(arb_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp", 32'(resp), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_chal_out", chal_out, 32'd0);
        reset = 1'b1;
        @(negedge clk);

`ifdef RACE_LAUNCHER_MAJORITY_EN
        // Per bit votes: {1,0,1} {0,0,1} {1,1,0} {0,1,0} -> 4'b0101
        run_req(32'hC3C3_0001, 16'h04E5, 16'h0000, 4'b0101, 1'b0);
        check("launches_per_request", 32'(launch_cnt - race_base), 32'd12);
`else
        run_req(32'hA5A5_0F0F, 16'h000D, 16'h0000, 4'b1101, 1'b0);
        check("launches_per_request", 32'(launch_cnt - race_base), 32'd4);
        run_req(32'h0000_0001, 16'h0006, 16'h0000, 4'b0110, 1'b0);
        // Race 2 never completes: bit 2 forced to 0 and the error flag set.
        run_req(32'h8000_0001, 16'h000F, 16'h0004, 4'b1011, 1'b1);
        run_req(32'h1234_5678, 16'h0008, 16'h0000, 4'b1000, 1'b0);

        // Reset during the wait of race 1 must abandon the request silently.
        pat_out    = 16'h0005;
        pat_nodone = 16'h0000;
        race_base  = launch_cnt;
        chal_q.push_back(32'hFFFF_0000);
        chal_q.push_back(32'hFFFE_0001);
        vbefore = valid_cnt;
        pulse_start(32'hFFFF_0000);
        for (int i = 0; i < 500 && (launch_cnt - race_base) < 2; i++) @(negedge clk);
        if ((launch_cnt - race_base) < 2) fail_event("race1_launch_wait_expired");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_launch", 32'(launch), 32'd0);
        check("midrst_arb_reset", 32'(arb_reset), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_resp", 32'(resp), 32'd0);
        check("midrst_chal_out", chal_out, 32'd0);
        repeat (200) @(negedge clk);
        check("no_resp_after_reset", 32'(valid_cnt), 32'(vbefore));

        // Second start while busy is dropped; the first challenge stays in use.
        pat_out    = 16'h0003;
        pat_nodone = 16'h0000;
        race_base  = launch_cnt;
        sb_q.push_back({1'b0, 4'b0011});
        push_chals(32'h0000_00F0);
        target = valid_cnt + 1;
        pulse_start(32'h0000_00F0);
        repeat (9) @(negedge clk);
        pulse_start(32'hDEAD_BEEF);
        wait_valid(target);
        repeat (100) @(negedge clk);
        check("single_resp_for_double_start", 32'(valid_cnt), 32'(target));
`endif

        repeat (20) @(negedge clk);
        check("resp_valid_total", 32'(valid_cnt), 32'(EXP_VALID));
        check("arb_reset_when_idle_launch", 32'(inv_err), 32'd0);
        check("chal_stable_during_race", 32'(stab_err), 32'd0);
        check("races_all_seen", 32'(chal_q.size()), 32'd0);
        check("responses_all_seen", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
